// File: rtl/double_dabble.sv
`default_nettype none
// ============================================================================
//  Module      : double_dabble
//  Description : Sequential binary-to-BCD converter (shift-and-add-3). Turns
//                an unsigned NUM_BITS value into four packed BCD digits, one
//                input bit per clock, and pulses a valid strobe on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module double_dabble #(
  parameter int NUM_BITS = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] binary_in,
  input  logic                binary_in_valid,
  output logic [15:0]         packed_bcd_out,
  output logic                packed_bcd_out_valid
);

  // Digits needed to hold 2^NUM_BITS-1 without overflow: ceil(N*log10(2)),
  // never fewer than the four digits presented on the output.
  localparam int c_digits_raw = (NUM_BITS * 30103 + 99999) / 100000;
  localparam int c_num_digits = (c_digits_raw < 4) ? 4 : c_digits_raw;
  localparam int c_bcd_w      = 4 * c_num_digits;
  localparam int c_cat_w      = c_bcd_w + NUM_BITS;
  localparam int c_cnt_w      = $clog2(NUM_BITS + 1);
  localparam logic [c_cnt_w-1:0] c_count_init = c_cnt_w'(NUM_BITS);
  localparam logic [c_cnt_w-1:0] c_count_last = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [NUM_BITS-1:0]  r_shift;
  logic [c_bcd_w-1:0]   r_scratch;
  logic [c_cnt_w-1:0]   r_count;
  logic [15:0]          r_bcd_out;
  logic                 r_bcd_valid;
  logic [c_bcd_w-1:0]   w_adj;
  logic [c_cat_w-1:0]   w_shifted;

  // Add-3 correction on every scratch digit that would exceed 9 once doubled
  genvar gi;
  generate
    for (gi = 0; gi < c_num_digits; gi++) begin : g_digit
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                              ? (r_scratch[4*gi +: 4] + 4'd3)
                              : r_scratch[4*gi +: 4];
    end
  endgenerate

  // Corrected scratch and binary shift register move left as one word
  assign w_shifted = {w_adj, r_shift} << 1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: one SHIFT cycle per input bit, then a single DONE cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (binary_in_valid) w_next_state = S_SHIFT;
      S_SHIFT: if (r_count == c_count_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: load on start, shift while busy, publish low four digits at DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= '0;
      r_scratch   <= '0;
      r_count     <= '0;
      r_bcd_out   <= 16'h0000;
      r_bcd_valid <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (binary_in_valid) begin
            r_shift   <= binary_in;
            r_scratch <= '0;
            r_count   <= c_count_init;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_shifted[c_cat_w-1:NUM_BITS];
          r_shift   <= w_shifted[NUM_BITS-1:0];
          r_count   <= r_count - c_count_last;
        end
        S_DONE: begin
          r_bcd_out   <= r_scratch[15:0];
          r_bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign packed_bcd_out       = r_bcd_out;
  assign packed_bcd_out_valid = r_bcd_valid;

endmodule
`default_nettype wire

// File: tb/tb_double_dabble.sv
`default_nettype none
// ============================================================================
//  Module      : tb_double_dabble
//  Description : Self-checking bench for double_dabble: vector table, corner
//                sequences and a random sweep, scored through a result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_double_dabble;

  localparam int NUM_BITS = 14;

  logic                clk;
  logic                reset;
  logic [NUM_BITS-1:0] binary_in;
  logic                binary_in_valid;
  logic [15:0]         packed_bcd_out;
  logic                packed_bcd_out_valid;

  int tests;
  int fails;
  int pulse_count;
  logic [15:0] sb[$];

  typedef struct {
    int          value;
    logic [15:0] expected;
  } vec_t;

  double_dabble #(.NUM_BITS(NUM_BITS)) dut (
    .clk                  (clk),
    .reset                (reset),
    .binary_in            (binary_in),
    .binary_in_valid      (binary_in_valid),
    .packed_bcd_out       (packed_bcd_out),
    .packed_bcd_out_valid (packed_bcd_out_valid)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits of value mod 10000
  function automatic logic [15:0] to_bcd(input int v);
    int m;
    m = v % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Monitor: scores every pulse, checks pulse width and output hold
  initial begin : monitor
    logic        prev_valid;
    logic [15:0] last_out;
    logic [15:0] exp;
    prev_valid = 1'b0;
    last_out   = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        tests++;
        if (packed_bcd_out !== 16'h0000 || packed_bcd_out_valid !== 1'b0) begin
          fails++;
          $display("FAIL reset_state: out=%h valid=%b, required out=0000 valid=0",
                   packed_bcd_out, packed_bcd_out_valid);
        end
        last_out   = 16'h0000;
        prev_valid = 1'b0;
      end else if (packed_bcd_out_valid === 1'b1) begin
        pulse_count++;
        tests++;
        if (prev_valid) begin
          fails++;
          $display("FAIL pulse_width: valid high two cycles in a row, required one");
        end
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: out=%h, required no pulse", packed_bcd_out);
        end else begin
          exp = sb.pop_front();
          if (packed_bcd_out !== exp) begin
            fails++;
            $display("FAIL result: out=%h, required %h", packed_bcd_out, exp);
          end
        end
        last_out   = packed_bcd_out;
        prev_valid = 1'b1;
      end else begin
        if (packed_bcd_out !== last_out) begin
          tests++;
          fails++;
          $display("FAIL hold: out=%h while valid low, required %h", packed_bcd_out, last_out);
        end
        prev_valid = 1'b0;
      end
    end
  end

  // Drive one start strobe for a cycle and queue its expected result
  task automatic start_conv(input int value);
    @(negedge clk);
    binary_in       = NUM_BITS'(value);
    binary_in_valid = 1'b1;
    sb.push_back(to_bcd(value));
    @(posedge clk);
    @(negedge clk);
    binary_in_valid = 1'b0;
    binary_in       = NUM_BITS'($urandom);
  endtask

  // Wait for the pulse of a start already accepted; cycles counted include
  // the accepting edge, so the required figure is NUM_BITS+2
  task automatic wait_valid(input string name, input int cycles_so_far);
    int n;
    n = cycles_so_far;
    while (packed_bcd_out_valid !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (packed_bcd_out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: no valid pulse within %0d cycles, required one", name, n);
    end else if (n != NUM_BITS + 2) begin
      fails++;
      $display("FAIL %s_latency: %0d cycles, required %0d", name, n, NUM_BITS + 2);
    end
  endtask

  task automatic convert(input string name, input int value);
    start_conv(value);
    // start_conv returns at the negedge after the accepting edge
    wait_valid(name, 1);
  endtask

  task automatic check_quiet(input string name, input int cycles, input logic [15:0] exp_out);
    int p0;
    p0 = pulse_count;
    repeat (cycles) @(posedge clk);
    #1;
    tests++;
    if (pulse_count != p0 || packed_bcd_out !== exp_out) begin
      fails++;
      $display("FAIL %s: pulses=%0d out=%h, required pulses=0 out=%h",
               name, pulse_count - p0, packed_bcd_out, exp_out);
    end
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    vec_t vecs[10];
    int   p0;
    tests = 0; fails = 0; pulse_count = 0;
    vecs[0] = '{0,     16'h0000};
    vecs[1] = '{1234,  16'h1234};
    vecs[2] = '{9999,  16'h9999};
    vecs[3] = '{7,     16'h0007};
    vecs[4] = '{10,    16'h0010};
    vecs[5] = '{16383, 16'h6383};
    vecs[6] = '{10000, 16'h0000};
    vecs[7] = '{1,     16'h0001};
    vecs[8] = '{5,     16'h0005};
    vecs[9] = '{8191,  16'h8191};

    reset = 1'b1; binary_in = '0; binary_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_quiet("idle_after_reset", 4, 16'h0000);

    // Table: results checked directly and also through the scoreboard
    for (int i = 0; i < 10; i++) begin
      convert("vec", vecs[i].value);
      tests++;
      if (packed_bcd_out !== vecs[i].expected) begin
        fails++;
        $display("FAIL vec%0d: value=%0d out=%h, required %h",
                 i, vecs[i].value, packed_bcd_out, vecs[i].expected);
      end
    end

    // Start while busy is ignored
    start_conv(42);
    @(posedge clk); @(negedge clk);
    binary_in = NUM_BITS'(99); binary_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    binary_in_valid = 1'b0;
    wait_valid("busy_ignore", 3);
    check_quiet("busy_no_extra", NUM_BITS + 4, 16'h0042);
    convert("after_busy", 99);

    // Reset mid-conversion aborts with no pulse
    start_conv(5678);
    repeat (4) @(posedge clk);
    @(negedge clk);
    sb.delete();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_quiet("abort_no_pulse", NUM_BITS + 6, 16'h0000);
    convert("after_abort", 321);

    // Random sweep
    for (int i = 0; i < 40; i++) begin
      convert("rand", int'($urandom_range(0, 16383)));
    end

    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    p0 = pulse_count;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/double_dabble.md
Name: double_dabble

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 ("double dabble") algorithm.
- Converts an unsigned NUM_BITS binary value into four packed BCD digits.
- Feeds the digit multiplexer of the seven-segment display driver.
- Processes one bit per clock and pulses a valid strobe when the result is ready.

Parameters:
- NUM_BITS, default 14, width of the unsigned binary input; must be ≥ 1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- binary_in  input  NUM_BITS  unsigned value to convert; sampled only on an accepted start.
- binary_in_valid  input  1  start strobe; accepted only when idle.
- packed_bcd_out  output  16  result digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- packed_bcd_out_valid  output  1  one-cycle pulse marking a new result on packed_bcd_out.

Interface: reset is named reset (synchronous, active-high); the clock is named clk.

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset forces the following, regardless of state:
  - state = IDLE
  - packed_bcd_out = 16'h0000
  - packed_bcd_out_valid = 0
  - internal shift register, BCD scratch register and bit counter = 0
- Reset mid-conversion aborts the conversion with no valid pulse.
- IDLE:
  - On binary_in_valid = 1: load binary_in into the shift register, clear the BCD scratch register, set bit counter = NUM_BITS, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, once per cycle:
  - For every scratch BCD digit ≥ 5, add 3 to that digit.
  - Then shift {scratch, shift register} left by 1; the MSB of the shift register enters scratch bit 0.
  - Decrement the counter.
  - After the iteration where the counter reaches 0, go to DONE.
- Scratch register width:
  - It holds enough digits for the full input range: ceil(NUM_BITS·log10(2)) digits, minimum 4.
  - Internal digits never overflow.
- DONE:
  - Register the low 16 bits of scratch (the four least significant digits) into packed_bcd_out.
  - Assert packed_bcd_out_valid for exactly this one cycle.
  - Return to IDLE.
- Latency: start accepted at edge T → packed_bcd_out updated and valid high in the cycle after edge T+NUM_BITS+1.
  - Busy duration is NUM_BITS+2 cycles including DONE.
- Inputs higher than 9999 produce value mod 10000 (upper digits dropped); no error flag.
- binary_in_valid while in SHIFT or DONE is ignored: not queued, no restart, input not re-sampled.
- A new start is accepted in the first IDLE cycle after DONE.
- packed_bcd_out holds its last result between conversions and only changes in DONE.
- packed_bcd_out_valid is never high for more than one consecutive cycle.
- binary_in may change freely after the start cycle.

Test Plan:
- Reset, then start with 0 → after NUM_BITS+2 cycles, single valid pulse with packed_bcd_out = 16'h0000; output stays 16'h0000 while valid is low.
- Starts with 1234, 9999, 7 and 10, each waiting for valid → outputs 16'h1234, 16'h9999, 16'h0007, 16'h0010; latency exactly NUM_BITS+2 cycles each.
- Start with 16383 (all ones, NUM_BITS=14) → 16'h6383 (mod 10000); start with 10000 → 16'h0000.
- Start with 42, then binary_in = 99 with valid asserted 3 cycles later → exactly one pulse, result 16'h0042; a new start after return to IDLE with 99 → 16'h0099.
- Start with 5678, assert reset mid-SHIFT → no valid pulse; output 16'h0000; a subsequent start with 321 → 16'h0321.
- Random sweep of 0..16383 against a reference model (value mod 10000 in BCD) → all match; the valid pulse is always exactly one cycle wide.
